// File: rtl/dbus_axi_bridge.sv
// Single-beat AXI3 master for the CPU data port: one bus transaction per CPU access.
// Optional macro DBUS_POSTED_WRITE_EN releases writes after AW/W and collects B in the background.
module dbus_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        dram_en,
  input  logic [3:0]  dram_wen,
  input  logic [31:0] dram_addr,
  input  logic [31:0] dram_wdata,
  output logic [31:0] dram_rdata,
  output logic        dram_sreq,
  input  logic        dram_stall,
  // AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // W channel
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B channel
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AWW, WR_B, DONE} state_e;

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        drop_q, drop_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        aw_hs, w_hs, drop_now, b_busy;

  // Responses and IDs are not checked; byte offset is dropped from the bus address.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, bid, bresp, dram_addr[1:0]};

`ifdef DBUS_POSTED_WRITE_EN
  logic b_pend_q, b_pend_d;
  assign b_busy = b_pend_q;
  assign bready = b_pend_q;
`else
  assign b_busy = 1'b0;
  assign bready = (state_q == WR_B);
`endif

  assign arid    = AXI_ID;
  assign araddr  = {addr_q, 2'b00};
  assign arlen   = 4'h0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'h0;
  assign arprot  = 3'h0;
  assign arvalid = (state_q == RD_AR);
  assign rready  = (state_q == RD_R);

  assign awid    = AXI_ID;
  assign awaddr  = {addr_q, 2'b00};
  assign awlen   = 4'h0;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'h0;
  assign awprot  = 3'h0;
  assign awvalid = (state_q == WR_AWW) && !aw_done_q;

  assign wid     = AXI_ID;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = (state_q == WR_AWW) && !w_done_q;

  assign aw_hs      = awvalid && awready;
  assign w_hs       = wvalid && wready;
  assign drop_now   = drop_q || flush;
  assign dram_sreq  = dram_en && (state_q != DONE);
  assign dram_rdata = rdata_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    drop_d    = drop_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifdef DBUS_POSTED_WRITE_EN
    b_pend_d  = b_pend_q;
    if (b_pend_q && bvalid) b_pend_d = 1'b0;
`endif
    // A flush mid-transaction only marks the result for discard; the bus side still completes.
    if (flush && (state_q != IDLE) && (state_q != DONE)) drop_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (dram_en && !flush && !b_busy) begin
          addr_d    = dram_addr[31:2];
          wdata_d   = dram_wdata;
          wstrb_d   = dram_wen;
          drop_d    = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (dram_wen == 4'h0) ? RD_AR : WR_AWW;
        end
      end
      RD_AR: if (arready) state_d = RD_R;
      RD_R: begin
        if (rvalid && rlast) begin
          if (!drop_now) rdata_d = rdata;
          state_d = drop_now ? IDLE : DONE;
          drop_d  = 1'b0;
        end
      end
      WR_AWW: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
`ifdef DBUS_POSTED_WRITE_EN
          b_pend_d = 1'b1;
          state_d  = drop_now ? IDLE : DONE;
          drop_d   = 1'b0;
`else
          state_d  = WR_B;
`endif
        end
      end
      WR_B: begin
        if (bvalid) begin
          state_d = drop_now ? IDLE : DONE;
          drop_d  = 1'b0;
        end
      end
      DONE: if (flush || !dram_stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      drop_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      drop_q    <= drop_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

`ifdef DBUS_POSTED_WRITE_EN
  always_ff @(posedge clk) begin
    if (rst) b_pend_q <= 1'b0;
    else     b_pend_q <= b_pend_d;
  end
`endif

endmodule
